// File: rtl/dircc_multi_send_handler_if.sv
// Shared DiRCC device-state/packet types and the handler's memory/router-facing bundle.
// master is the handler's view; slave is the memory/router environment's view.
package dircc_multi_send_handler_pkg;
   localparam int DIRCC_STATE_WIDTH = 8;
   localparam int USER_STATE_WIDTH  = 288;
   localparam int PACKET_DATA_WIDTH = 32;

   localparam logic [DIRCC_STATE_WIDTH-1:0] DIRCC_STATE_RUNNING = 8'h01;
   localparam logic [DIRCC_STATE_WIDTH-1:0] DIRCC_STATE_DONE    = 8'h04;
   localparam logic [DIRCC_STATE_WIDTH-1:0] DIRCC_STATE_STOPPED = 8'h08;

   typedef struct packed {
      logic [DIRCC_STATE_WIDTH-1:0] dircc_state;
      logic [DIRCC_STATE_WIDTH-1:0] dircc_state_extra;
      logic [USER_STATE_WIDTH-1:0]  user_state;
   } device_state_t;

   typedef logic [PACKET_DATA_WIDTH-1:0] packet_data_t;
endpackage

interface dircc_multi_send_handler_if #(
   parameter int ADDRESS_MEM_WIDTH = 32,
   parameter int PIN_WIDTH         = 2
);
   import dircc_multi_send_handler_pkg::*;

   logic [ADDRESS_MEM_WIDTH-1:0] address;
   device_state_t                read_state;
   logic                         read_state_valid;
   packet_data_t                 packet_out;
   logic [PIN_WIDTH-1:0]         packet_out_pin;
   logic                         packet_out_valid;
   logic                         packet_out_ready;
   device_state_t                write_state;
   logic                         write_state_valid;
   logic                         busy;

   modport master (
      input  address, read_state, read_state_valid, packet_out_ready,
      output packet_out, packet_out_pin, packet_out_valid,
             write_state, write_state_valid, busy
   );

   modport slave (
      output address, read_state, read_state_valid, packet_out_ready,
      input  packet_out, packet_out_pin, packet_out_valid,
             write_state, write_state_valid, busy
   );
endinterface

// File: rtl/dircc_multi_send_handler.sv
// Multi-pin DiRCC send handler: round-robin pin pick, one packet per activation, state write-back.
// Define DIRCC_SEND_HANDLER_BROADCAST_EN to serve every pending pin once per activation.
module dircc_multi_send_handler
   import dircc_multi_send_handler_pkg::*;
#(
   parameter int ADDRESS_MEM_WIDTH = 32,
   parameter int NUM_PINS          = 4,
   parameter int RTS_WIDTH         = 16,
   parameter int COUNT_WIDTH       = 16
) (
   input logic clk,
   input logic reset_n,
   dircc_multi_send_handler_if.master bus
);
   localparam int PIN_W     = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
   localparam int COUNT_LSB = NUM_PINS * RTS_WIDTH;

   typedef enum logic [1:0] {IDLE, SEND, WRITEBACK} fsm_t;

   fsm_t                         state, state_next;
   device_state_t                held;
   logic [ADDRESS_MEM_WIDTH-1:0] held_address_unused;
   logic [PIN_W-1:0]             rr_ptr, sel_pin, entry_pin;
   logic [NUM_PINS-1:0]          in_nz, held_nz;
   logic                         entry_found;
   logic [USER_STATE_WIDTH-1:0]  dec_user;
   logic                         start, accept;
`ifdef DIRCC_SEND_HANDLER_BROADCAST_EN
   logic [NUM_PINS-1:0]          served, dec_nz;
   logic [PIN_W-1:0]             cont_pin;
   logic                         cont_found;
`endif

   // Returns {found, pin}: first set mask bit searching upward from from+1, wrapping.
   function automatic logic [PIN_W:0] pick_next(input logic [NUM_PINS-1:0] mask,
                                                input logic [PIN_W-1:0] from);
      logic             found;
      logic [PIN_W-1:0] pin;
      int               idx;
      found = 1'b0;
      pin   = '0;
      for (int k = 1; k <= NUM_PINS; k++) begin
         idx = int'(from) + k;
         if (idx >= NUM_PINS) idx = idx - NUM_PINS;
         if (!found && mask[PIN_W'(idx)]) begin
            found = 1'b1;
            pin   = PIN_W'(idx);
         end
      end
      return {found, pin};
   endfunction

   always_comb begin
      in_nz    = '0;
      held_nz  = '0;
      dec_user = held.user_state;
      for (int p = 0; p < NUM_PINS; p++) begin
         in_nz[p]   = |bus.read_state.user_state[p*RTS_WIDTH +: RTS_WIDTH];
         held_nz[p] = |held.user_state[p*RTS_WIDTH +: RTS_WIDTH];
         if (PIN_W'(p) == sel_pin)
            dec_user[p*RTS_WIDTH +: RTS_WIDTH] = held.user_state[p*RTS_WIDTH +: RTS_WIDTH] - RTS_WIDTH'(1);
      end
      {entry_found, entry_pin} = pick_next(in_nz, rr_ptr);
   end

`ifdef DIRCC_SEND_HANDLER_BROADCAST_EN
   // Next pin still pending after this decrement that has not been served this activation.
   always_comb begin
      dec_nz = '0;
      for (int p = 0; p < NUM_PINS; p++)
         dec_nz[p] = |dec_user[p*RTS_WIDTH +: RTS_WIDTH];
      {cont_found, cont_pin} = pick_next(dec_nz & ~served, sel_pin);
   end
`endif

   always_comb begin
      state_next = state;
      start      = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.read_state_valid && entry_found) begin
               start      = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            if (bus.packet_out_ready) begin
               accept = 1'b1;
`ifdef DIRCC_SEND_HANDLER_BROADCAST_EN
               state_next = cont_found ? SEND : WRITEBACK;
`else
               state_next = WRITEBACK;
`endif
            end
         end
         WRITEBACK: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   assign bus.packet_out_valid  = (state == SEND);
   assign bus.write_state_valid = (state == WRITEBACK);
   assign bus.busy              = (state != IDLE);
   assign bus.packet_out_pin    = sel_pin;
   assign bus.packet_out        = packet_data_t'(held.user_state[COUNT_LSB +: COUNT_WIDTH]);

   // A DONE device whose last pending send has drained is marked stopped.
   always_comb begin
      bus.write_state = held;
      if (~|held_nz && |(held.dircc_state & DIRCC_STATE_DONE))
         bus.write_state.dircc_state = DIRCC_STATE_DONE | DIRCC_STATE_STOPPED;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state               <= IDLE;
         held                <= '0;
         held_address_unused <= '0;
         rr_ptr              <= PIN_W'(NUM_PINS - 1);
         sel_pin             <= '0;
`ifdef DIRCC_SEND_HANDLER_BROADCAST_EN
         served              <= '0;
`endif
      end else begin
         state <= state_next;
         if (start) begin
            held                <= bus.read_state;
            held_address_unused <= bus.address;
            sel_pin             <= entry_pin;
`ifdef DIRCC_SEND_HANDLER_BROADCAST_EN
            served              <= NUM_PINS'(1) << entry_pin;
`endif
         end
         if (accept) begin
            held.user_state <= dec_user;
            rr_ptr          <= sel_pin;
`ifdef DIRCC_SEND_HANDLER_BROADCAST_EN
            if (cont_found) begin
               sel_pin <= cont_pin;
               served  <= served | (NUM_PINS'(1) << cont_pin);
            end
`endif
         end
      end
   end
endmodule
